// File: rtl/uart_cmd_framer.sv
// Frames three UART bytes into a 24-bit command and relays one-byte responses to the UART transmitter.
// Optional inter-byte timeout for partial frames is enabled by defining CMD_TIMEOUT_EN.
module uart_cmd_framer #(
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic [23:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp_data,
    input  logic        send_resp,
    output logic        trmt,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        resp_sent,
    output logic        tx_busy,
    output logic        frame_err,
    output logic [1:0]  o_rx_state,
    output logic        o_tx_state
);

    // Handshake: a byte is taken when rx_rdy=1 while clr_rx_rdy=0 and the frame is not full;
    // the one-cycle clr_rx_rdy pulse that follows tells the UART the byte was consumed.
    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_B2   = 2'd1,
        RX_B3   = 2'd2,
        RX_HOLD = 2'd3
    } rx_state_t;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_WAIT = 1'b1
    } tx_state_t;

    rx_state_t   r_rx_state;
    rx_state_t   w_rx_next;
    tx_state_t   r_tx_state;
    tx_state_t   w_tx_next;

    logic        r_clr_rx_rdy;
    logic [23:0] r_cmd;
    logic        r_cmd_rdy;
    logic        w_consume;
    logic        w_timeout;

    logic        r_tx_done_prev;
    logic        r_trmt;
    logic [7:0]  r_tx_data;
    logic        r_resp_sent;
    logic        w_tx_rise;
    logic        w_tx_start;
    logic        w_tx_finish;

    assign w_consume = rx_rdy && !r_clr_rx_rdy && (r_rx_state != RX_HOLD);

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE: if (w_consume) w_rx_next = RX_B2;
            RX_B2: begin
                if (w_consume)      w_rx_next = RX_B3;
                else if (w_timeout) w_rx_next = RX_IDLE;
            end
            RX_B3: begin
                if (w_consume)      w_rx_next = RX_HOLD;
                else if (w_timeout) w_rx_next = RX_IDLE;
            end
            RX_HOLD: if (clr_cmd_rdy) w_rx_next = RX_IDLE;
            default: w_rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state   <= RX_IDLE;
            r_clr_rx_rdy <= 1'b0;
            r_cmd        <= 24'd0;
            r_cmd_rdy    <= 1'b0;
        end else begin
            r_rx_state   <= w_rx_next;
            r_clr_rx_rdy <= w_consume;
            r_cmd_rdy    <= (w_rx_next == RX_HOLD);
            if (w_consume) begin
                case (r_rx_state)
                    RX_IDLE: r_cmd[23:16] <= rx_data;
                    RX_B2:   r_cmd[15:8]  <= rx_data;
                    RX_B3:   r_cmd[7:0]   <= rx_data;
                    default: r_cmd        <= r_cmd;
                endcase
            end
        end
    end

`ifdef CMD_TIMEOUT_EN
    logic [19:0] r_to_cnt;
    logic        r_frame_err;
    logic        w_in_wait;

    assign w_in_wait = (r_rx_state == RX_B2) || (r_rx_state == RX_B3);
    assign w_timeout = w_in_wait && !w_consume && (r_to_cnt == TIMEOUT_CYCLES - 20'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt    <= 20'd0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_consume || !w_in_wait || w_timeout) r_to_cnt <= 20'd0;
            else                                      r_to_cnt <= r_to_cnt + 20'd1;
            // A completed frame supersedes any earlier discarded one.
            if (w_timeout)                                          r_frame_err <= 1'b1;
            else if (w_rx_next == RX_HOLD && r_rx_state != RX_HOLD) r_frame_err <= 1'b0;
        end
    end

    assign frame_err = r_frame_err;
`else
    // Partial frames wait forever; the parameter stays only to keep one interface for both builds.
    assign w_timeout = (TIMEOUT_CYCLES == 20'd0) && 1'b0;
    assign frame_err = 1'b0;
`endif

    assign w_tx_rise = tx_done && !r_tx_done_prev;

    always_comb begin
        w_tx_next   = r_tx_state;
        w_tx_start  = 1'b0;
        w_tx_finish = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                if (send_resp) begin
                    w_tx_start = 1'b1;
                    w_tx_next  = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (w_tx_rise) begin
                    w_tx_finish = 1'b1;
                    w_tx_next   = TX_IDLE;
                end
            end
            default: w_tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state     <= TX_IDLE;
            r_tx_done_prev <= 1'b0;
            r_trmt         <= 1'b0;
            r_tx_data      <= 8'd0;
            r_resp_sent    <= 1'b0;
        end else begin
            r_tx_state     <= w_tx_next;
            r_tx_done_prev <= tx_done;
            r_trmt         <= w_tx_start;
            r_resp_sent    <= w_tx_finish;
            if (w_tx_start) r_tx_data <= resp_data;
        end
    end

    assign clr_rx_rdy = r_clr_rx_rdy;
    assign cmd        = r_cmd;
    assign cmd_rdy    = r_cmd_rdy;
    assign trmt       = r_trmt;
    assign tx_data    = r_tx_data;
    assign resp_sent  = r_resp_sent;
    assign tx_busy    = (r_tx_state == TX_WAIT);
    assign o_rx_state = r_rx_state;
    assign o_tx_state = r_tx_state;

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Self-checking bench for uart_cmd_framer: byte-queue frame model, response path checks.
// Build with CMD_TIMEOUT_EN defined to exercise the partial-frame timeout.
module tb_uart_cmd_framer;

    localparam int T = 100;
`ifdef CMD_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp_data;
    logic        send_resp;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        resp_sent;
    logic        tx_busy;
    logic        frame_err;
    logic [1:0]  o_rx_state;
    logic        o_tx_state;

    int checks = 0;
    int failures = 0;
    int n_clr = 0;
    int n_trmt = 0;
    int n_rs = 0;

    // Reference model: consumed bytes accumulate into a partial frame; every third byte completes a command.
    logic [7:0]  part_q[$];
    logic [23:0] exp_q[$];
    bit          exp_ferr = 1'b0;

    uart_cmd_framer #(.TIMEOUT_CYCLES(20'd100)) dut (
        .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data), .clr_rx_rdy(clr_rx_rdy),
        .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .resp_data(resp_data),
        .send_resp(send_resp), .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done),
        .resp_sent(resp_sent), .tx_busy(tx_busy), .frame_err(frame_err),
        .o_rx_state(o_rx_state), .o_tx_state(o_tx_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (clr_rx_rdy) n_clr++;
        if (trmt)       n_trmt++;
        if (resp_sent)  n_rs++;
    end

    function automatic void model_byte(input logic [7:0] b);
        part_q.push_back(b);
        if (part_q.size() == 3) begin
            exp_q.push_back({part_q[0], part_q[1], part_q[2]});
            part_q.delete();
            exp_ferr = 1'b0;
        end
    endfunction

    function automatic void model_idle(input int cycles);
        if (TO_EN && part_q.size() > 0 && cycles >= T) begin
            part_q.delete();
            exp_ferr = 1'b1;
        end
    endfunction

    function automatic void model_reset();
        part_q.delete();
        exp_q.delete();
        exp_ferr = 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one byte and waits (bounded) for the consume pulse.
    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        rx_data = b;
        rx_rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (clr_rx_rdy) begin
                ok = 1'b1;
                break;
            end
        end
        rx_rdy = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL send_byte_timeout: byte %h consumed=%0b required=1", b, ok);
        end
        model_byte(b);
    endtask

    task automatic ack_cmd();
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        model_reset();
        checks++; if (cmd !== 24'd0) begin failures++; $display("FAIL reset_cmd: got %h expected 000000", cmd); end
        checks++; if ({clr_rx_rdy, cmd_rdy, trmt, resp_sent, tx_busy, frame_err} !== 6'd0) begin
            failures++; $display("FAIL reset_flags: got %b expected 000000", {clr_rx_rdy, cmd_rdy, trmt, resp_sent, tx_busy, frame_err}); end
        checks++; if (tx_data !== 8'd0) begin failures++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        checks++; if (o_rx_state !== 2'd0 || o_tx_state !== 1'b0) begin
            failures++; $display("FAIL reset_state: got %0d/%0d expected 0/0", o_rx_state, o_tx_state); end
    endtask

    task automatic test_basic();
        int n0;
        logic [23:0] e;
        n0 = n_clr;
        send_byte(8'h02);
        send_byte(8'h0D);
        checks++; if (cmd_rdy !== 1'b0) begin failures++; $display("FAIL basic_early_rdy: got %b expected 0", cmd_rdy); end
        send_byte(8'h00);
        e = exp_q.pop_front();
        checks++; if (cmd_rdy !== 1'b1) begin failures++; $display("FAIL basic_cmd_rdy: got %b expected 1", cmd_rdy); end
        checks++; if (cmd !== e) begin failures++; $display("FAIL basic_cmd: got %h expected %h", cmd, e); end
        repeat (3) tick();
        checks++; if (n_clr - n0 !== 3) begin failures++; $display("FAIL basic_clr_count: got %0d expected 3", n_clr - n0); end
        ack_cmd();
        checks++; if (cmd_rdy !== 1'b0) begin failures++; $display("FAIL basic_ack: got %b expected 0", cmd_rdy); end
    endtask

    task automatic test_backpressure();
        int n0;
        bit ok;
        logic [23:0] e;
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h00);
        e = exp_q.pop_front();
        rx_data = 8'h07;
        rx_rdy = 1'b1;
        n0 = n_clr;
        repeat (10) tick();
        checks++; if (n_clr - n0 !== 1) begin failures++; $display("FAIL hold_no_consume: pulses %0d expected 1", n_clr - n0); end
        checks++; if (cmd !== e || cmd_rdy !== 1'b1) begin
            failures++; $display("FAIL hold_stable: got %h/%b expected %h/1", cmd, cmd_rdy, e); end
        ack_cmd();
        checks++; if (cmd_rdy !== 1'b0 || clr_rx_rdy !== 1'b0) begin
            failures++; $display("FAIL hold_release: got rdy=%b clr=%b expected 0/0", cmd_rdy, clr_rx_rdy); end
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (clr_rx_rdy) begin ok = 1'b1; break; end
        end
        rx_rdy = 1'b0;
        model_byte(8'h07);
        checks++; if (!ok || cmd[23:16] !== 8'h07) begin
            failures++; $display("FAIL hold_next_byte: consumed=%b cmd_hi=%h expected 1/07", ok, cmd[23:16]); end
        send_byte(8'($urandom_range(0, 255)));
        send_byte(8'($urandom_range(0, 255)));
        e = exp_q.pop_front();
        checks++; if (cmd !== e) begin failures++; $display("FAIL hold_frame2: got %h expected %h", cmd, e); end
        ack_cmd();
    endtask

    task automatic test_tx();
        logic [7:0] r;
        int n0;
        for (int k = 0; k < 5; k++) begin
            r = (k == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
            n0 = n_rs;
            resp_data = r;
            send_resp = 1'b1;
            tick();
            send_resp = 1'b0;
            checks++; if (trmt !== 1'b1 || tx_data !== r || tx_busy !== 1'b1) begin
                failures++; $display("FAIL tx_start: got trmt=%b data=%h busy=%b expected 1/%h/1", trmt, tx_data, tx_busy, r); end
            resp_data = ~r;
            send_resp = 1'b1;
            tick();
            send_resp = 1'b0;
            checks++; if (trmt !== 1'b0 || tx_data !== r) begin
                failures++; $display("FAIL tx_ignore: got trmt=%b data=%h expected 0/%h", trmt, tx_data, r); end
            repeat ($urandom_range(0, 4)) tick();
            checks++; if (tx_busy !== 1'b1 || resp_sent !== 1'b0) begin
                failures++; $display("FAIL tx_wait: got busy=%b sent=%b expected 1/0", tx_busy, resp_sent); end
            tx_done = 1'b1;
            tick();
            checks++; if (resp_sent !== 1'b1 || tx_busy !== 1'b0) begin
                failures++; $display("FAIL tx_done: got sent=%b busy=%b expected 1/0", resp_sent, tx_busy); end
            tick();
            tick();
            tx_done = 1'b0;
            tick();
            checks++; if (n_rs - n0 !== 1) begin failures++; $display("FAIL tx_single_pulse: got %0d expected 1", n_rs - n0); end
        end
    endtask

    task automatic test_timeout();
        logic [23:0] e;
        logic [1:0]  es;
        send_byte(8'h08);
        repeat (50) tick();
        es = 2'(part_q.size());
        checks++; if (o_rx_state !== es) begin failures++; $display("FAIL to_mid_state: got %0d expected %0d", o_rx_state, es); end
        repeat (100) tick();
        model_idle(150);
        es = 2'(part_q.size());
        checks++; if (o_rx_state !== es) begin failures++; $display("FAIL to_state: got %0d expected %0d", o_rx_state, es); end
        checks++; if (frame_err !== exp_ferr) begin failures++; $display("FAIL to_frame_err: got %b expected %b", frame_err, exp_ferr); end
        send_byte(8'h09);
        send_byte(8'h10);
        if (part_q.size() != 0) send_byte(8'h00);
        e = exp_q.pop_front();
        checks++; if (cmd !== e || cmd_rdy !== 1'b1) begin
            failures++; $display("FAIL to_next_cmd: got %h/%b expected %h/1", cmd, cmd_rdy, e); end
        checks++; if (frame_err !== exp_ferr) begin failures++; $display("FAIL to_err_clear: got %b expected %b", frame_err, exp_ferr); end
        ack_cmd();
    endtask

    task automatic test_reset_mid();
        logic [23:0] e;
        resp_data = 8'h5A;
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        send_byte(8'h03);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        checks++; if (cmd !== 24'd0 || tx_data !== 8'd0) begin
            failures++; $display("FAIL rstmid_data: got cmd=%h tx=%h expected 000000/00", cmd, tx_data); end
        checks++; if ({clr_rx_rdy, cmd_rdy, trmt, resp_sent, tx_busy, frame_err, o_rx_state} !== 8'd0) begin
            failures++; $display("FAIL rstmid_flags: got %b expected 00000000", {clr_rx_rdy, cmd_rdy, trmt, resp_sent, tx_busy, frame_err, o_rx_state}); end
        send_byte(8'h04);
        send_byte(8'h01);
        send_byte(8'h00);
        e = exp_q.pop_front();
        checks++; if (cmd !== e || cmd_rdy !== 1'b1) begin
            failures++; $display("FAIL rstmid_cmd: got %h/%b expected %h/1", cmd, cmd_rdy, e); end
        ack_cmd();
    endtask

    task automatic test_concurrent();
        logic [7:0]  r, b3;
        logic [23:0] e;
        send_byte(8'($urandom_range(0, 255)));
        send_byte(8'($urandom_range(0, 255)));
        tick();
        r  = 8'($urandom_range(0, 255));
        b3 = 8'($urandom_range(0, 255));
        rx_data = b3;
        rx_rdy = 1'b1;
        resp_data = r;
        send_resp = 1'b1;
        tick();
        rx_rdy = 1'b0;
        send_resp = 1'b0;
        model_byte(b3);
        e = exp_q.pop_front();
        checks++; if (clr_rx_rdy !== 1'b1 || cmd_rdy !== 1'b1 || cmd !== e) begin
            failures++; $display("FAIL conc_rx: got clr=%b rdy=%b cmd=%h expected 1/1/%h", clr_rx_rdy, cmd_rdy, cmd, e); end
        checks++; if (trmt !== 1'b1 || tx_data !== r || tx_busy !== 1'b1) begin
            failures++; $display("FAIL conc_tx: got trmt=%b data=%h busy=%b expected 1/%h/1", trmt, tx_data, tx_busy, r); end
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        checks++; if (resp_sent !== 1'b1 || cmd_rdy !== 1'b1 || cmd !== e) begin
            failures++; $display("FAIL conc_done: got sent=%b rdy=%b cmd=%h expected 1/1/%h", resp_sent, cmd_rdy, cmd, e); end
        ack_cmd();
        checks++; if (cmd_rdy !== 1'b0 || tx_busy !== 1'b0) begin
            failures++; $display("FAIL conc_end: got rdy=%b busy=%b expected 0/0", cmd_rdy, tx_busy); end
    endtask

    task automatic test_random_frames();
        int n0;
        int gap;
        logic [23:0] e;
        n0 = n_clr;
        for (int f = 0; f < 12; f++) begin
            for (int b = 0; b < 3; b++) begin
                gap = $urandom_range(0, 3);
                repeat (gap) tick();
                model_idle(gap);
                send_byte(8'($urandom));
            end
            e = exp_q.pop_front();
            checks++; if (cmd_rdy !== 1'b1 || cmd !== e) begin
                failures++; $display("FAIL rand_cmd: frame %0d got %h/%b expected %h/1", f, cmd, cmd_rdy, e); end
            repeat ($urandom_range(0, 4)) tick();
            checks++; if (cmd !== e) begin failures++; $display("FAIL rand_stable: frame %0d got %h expected %h", f, cmd, e); end
            ack_cmd();
            checks++; if (cmd_rdy !== 1'b0) begin failures++; $display("FAIL rand_ack: frame %0d got %b expected 0", f, cmd_rdy); end
        end
        tick();
        checks++; if (n_clr - n0 !== 36) begin failures++; $display("FAIL rand_clr_count: got %0d expected 36", n_clr - n0); end
        checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL rand_leftover: got %0d expected 0", exp_q.size()); end
    endtask

    initial begin
        rst = 1'b1;
        rx_rdy = 1'b0;
        rx_data = 8'd0;
        clr_cmd_rdy = 1'b0;
        resp_data = 8'd0;
        send_resp = 1'b0;
        tx_done = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_tx();
        test_timeout();
        test_reset_mid();
        test_concurrent();
        test_random_frames();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_cmd_framer.md
UART_CMD_FRAMER -- requirements
Module: uart_cmd_framer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 20'd500000: maximum idle cycles between bytes of one command frame.
REQ-002 SHALL have port clk  input  1  the single system clock; all logic SHALL be clocked on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port rx_rdy  input  1  UART receive byte available (level).
REQ-005 SHALL have port rx_data  input  8  UART received byte.
REQ-006 SHALL have port clr_rx_rdy  output  1  registered one-cycle pulse that consumes the UART byte.
REQ-007 SHALL have port cmd  output  24  assembled command, {byte1, byte2, byte3}.
REQ-008 SHALL have port cmd_rdy  output  1  assembled command valid (level).
REQ-009 SHALL have port clr_cmd_rdy  input  1  command consumer acknowledge.
REQ-010 SHALL have port resp_data  input  8  response byte to transmit.
REQ-011 SHALL have port send_resp  input  1  one-cycle request to transmit resp_data.
REQ-012 SHALL have port trmt  output  1  one-cycle UART transmit strobe.
REQ-013 SHALL have port tx_data  output  8  byte presented to UART transmitter.
REQ-014 SHALL have port tx_done  input  1  UART transmit-complete level; a rising edge marks completion.
REQ-015 SHALL have port resp_sent  output  1  one-cycle pulse when the response has been transmitted.
REQ-016 SHALL have port tx_busy  output  1  high while a response is in flight.
REQ-017 SHALL have port frame_err  output  1  sticky flag set when a partial frame is discarded.

Function
REQ-018 The receive FSM SHALL have states IDLE, B2, B3 and HOLD.
REQ-019 A byte SHALL be consumed in a cycle where rx_rdy=1, clr_rx_rdy=0 and the state is IDLE, B2 or B3; clr_rx_rdy SHALL pulse high for exactly one cycle, in the next cycle.
REQ-020 A byte consumed in IDLE, B2 or B3 SHALL be stored into cmd[23:16], cmd[15:8] or cmd[7:0] respectively, and the state SHALL advance IDLE->B2->B3->HOLD.
REQ-021 cmd_rdy SHALL rise in the cycle after the third byte is consumed, and cmd SHALL be stable while cmd_rdy=1.
REQ-022 In HOLD, no byte SHALL be consumed and clr_rx_rdy SHALL stay 0, so that the UART applies backpressure.
REQ-023 clr_cmd_rdy=1 in HOLD SHALL clear cmd_rdy the next cycle and return the FSM to IDLE; clr_cmd_rdy SHALL be ignored in all other states.
REQ-024 If rx_rdy and clr_cmd_rdy are both high in HOLD, the byte SHALL be consumed no earlier than the cycle after the FSM reaches IDLE.
REQ-025 frame_err SHALL be cleared when cmd_rdy rises.
REQ-026 The transmit FSM SHALL have states TX_IDLE and TX_WAIT, and SHALL operate independently of the receive FSM.
REQ-027 send_resp in TX_IDLE SHALL latch resp_data into tx_data, assert trmt for the next cycle only, and enter TX_WAIT; tx_busy SHALL equal (state==TX_WAIT).
REQ-028 In TX_WAIT, a tx_done rising edge (registered previous-value compare) SHALL pulse resp_sent for one cycle and return to TX_IDLE.
REQ-029 send_resp in TX_WAIT SHALL be ignored, with tx_data unchanged.

Reset
REQ-030 rst SHALL force both FSMs to IDLE/TX_IDLE and clear cmd, tx_data and all output flags to 0 on the next clock edge.
REQ-031 rst SHALL discard any partial frame mid-operation without setting frame_err.

Configuration
REQ-032 Macro CMD_TIMEOUT_EN: when defined, a counter SHALL clear on every byte consumption, count each cycle spent in B2 or B3, and on reaching TIMEOUT_CYCLES-1 SHALL return the FSM to IDLE and set frame_err.
REQ-033 Without CMD_TIMEOUT_EN, no counter SHALL exist, frame_err SHALL be tied to 0, and B2/B3 SHALL wait indefinitely.

Verification
REQ-034 Bytes 0x02,0x0D,0x00 sent -> cmd=24'h020D00 and cmd_rdy=1 one cycle after the third consume; exactly three clr_rx_rdy pulses.
REQ-035 Command 0x01,0x02,0x00 held without clr_cmd_rdy while 0x07 arrives -> no clr_rx_rdy; after clr_cmd_rdy, 0x07 is consumed into cmd[23:16].
REQ-036 send_resp with resp_data=8'hA5 -> trmt one cycle later with tx_data=8'hA5; a second send_resp during TX_WAIT is ignored; tx_done edge -> single resp_sent pulse.
REQ-037 With CMD_TIMEOUT_EN and TIMEOUT_CYCLES=100: 0x08 then a 150-cycle gap -> FSM back in IDLE, frame_err=1; then 0x09,0x10,0x00 -> cmd=24'h091000, frame_err=0.
REQ-038 rst asserted after byte 0x03 has been consumed -> all outputs 0; then 0x04,0x01,0x00 -> cmd=24'h040100.
REQ-039 send_resp asserted in the same cycle as the third rx byte -> both the cmd_rdy and trmt sequences complete correctly and independently.
